tl45_fetch: RTL and testbench

Instruction-fetch stage of the TL45 pipeline; it sits at the upstream end of the stall/flush chain and the branch-redirect path. Fetches one 32-bit instruction word per request over a pipelined Wishbone master port and presents {pc, instruction} in a buffer to decode. Honours downstream stall and flush. On a taken branch it accepts a new PC from execute (execute's new-PC strobe and branch-target PC outputs). Bubbles are all-zero buffer contents; opcode 0 is a NOP everywhere downstream.

---
 rtl/tl45_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_tl45_fetch.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl45_fetch.sv
// rtl/tl45_fetch.sv - TL45 instruction fetch stage; optional bus-error handling under TL45_FETCH_BUSERR_EN
module tl45_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic        i_ld_newpc,
  input  logic [31:0] i_new_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [29:0] o_wb_addr,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
`ifdef TL45_FETCH_BUSERR_EN
  input  logic        i_wb_err,
  output logic        o_buserr,
`endif
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] hold_inst;
  logic        hold_err;
  logic        park;

  logic        redirect;
  logic        in_flight;
  logic        bus_ack;
  logic        bus_err;
  logic        wb_err;

  logic        load_bus;
  logic        load_hold;
  logic        load_err;
  logic        hold_latch;
  logic        hold_err_latch;

  logic        unused_low_bits;

`ifdef TL45_FETCH_BUSERR_EN
  assign wb_err = i_wb_err;
`else
  assign wb_err = 1'b0;
`endif

  // Target low bits are forced to zero; they never reach the pc.
  assign unused_low_bits = ^i_new_pc[1:0];

  assign redirect  = i_pipe_flush | i_ld_newpc;
  // A request is on the bus once the slave has taken the strobe; an ack
  // arriving in the accepting cycle is handled exactly like one in S_WAIT.
  assign in_flight = (state == S_WAIT) | ((state == S_REQ) & ~i_wb_stall);
  assign bus_ack   = in_flight & i_wb_ack;
  assign bus_err   = in_flight & wb_err;

  // pc is only changed outside S_REQ, so it doubles as the registered address.
  assign o_wb_addr = pc[31:2];

  // Bus control follows the state register directly.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    case (state)
      S_REQ:   begin o_wb_cyc = 1'b1; o_wb_stb = 1'b1; end
      S_WAIT:  o_wb_cyc = 1'b1;
      S_DRAIN: o_wb_cyc = 1'b1;
      default: ;
    endcase
  end

  // Next-state and datapath strobes; redirect overrides every bus event.
  always_comb begin
    state_next     = state;
    load_bus       = 1'b0;
    load_hold      = 1'b0;
    load_err       = 1'b0;
    hold_latch     = 1'b0;
    hold_err_latch = 1'b0;
    if (redirect) begin
      // A request still in flight must have its response swallowed.
      if (in_flight && !(i_wb_ack || wb_err))
        state_next = S_DRAIN;
      else
        state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!park)
            state_next = S_REQ;
        end
        S_REQ, S_WAIT: begin
          if (bus_err) begin
            if (i_pipe_stall) begin
              hold_err_latch = 1'b1;
              state_next     = S_HOLD;
            end else begin
              load_err   = 1'b1;
              state_next = S_IDLE;
            end
          end else if (bus_ack) begin
            if (i_pipe_stall) begin
              hold_latch = 1'b1;
              state_next = S_HOLD;
            end else begin
              load_bus   = 1'b1;
              state_next = S_REQ;
            end
          end else if (state == S_REQ && !i_wb_stall) begin
            state_next = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            if (hold_err) begin
              load_err   = 1'b1;
              state_next = S_IDLE;
            end else begin
              load_hold  = 1'b1;
              state_next = S_REQ;
            end
          end
        end
        S_DRAIN: begin
          if (i_wb_ack || wb_err)
            state_next = S_REQ;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // PC, hold register and decode buffer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc         <= RESET_PC;
      hold_inst  <= 32'h0;
      hold_err   <= 1'b0;
      park       <= 1'b0;
      o_buf_pc   <= 32'h0;
      o_buf_inst <= 32'h0;
    end else if (redirect) begin
      hold_inst  <= 32'h0;
      hold_err   <= 1'b0;
      park       <= 1'b0;
      o_buf_pc   <= 32'h0;
      o_buf_inst <= 32'h0;
      if (i_ld_newpc)
        pc <= {i_new_pc[31:2], 2'b00};
    end else begin
      if (hold_latch) begin
        hold_inst <= i_wb_data;
        hold_err  <= 1'b0;
      end
      if (hold_err_latch) begin
        hold_inst <= 32'h0;
        hold_err  <= 1'b1;
      end
      if (!i_pipe_stall) begin
        o_buf_pc   <= 32'h0;
        o_buf_inst <= 32'h0;
        if (load_bus) begin
          o_buf_pc   <= pc;
          o_buf_inst <= i_wb_data;
          pc         <= pc + 32'd4;
        end else if (load_hold) begin
          o_buf_pc   <= pc;
          o_buf_inst <= hold_inst;
          hold_inst  <= 32'h0;
          pc         <= pc + 32'd4;
        end else if (load_err) begin
          // Faulting pc is reported but not advanced; fetch parks until redirect.
          o_buf_pc   <= pc;
          o_buf_inst <= 32'h0;
          hold_err   <= 1'b0;
          park       <= 1'b1;
        end
      end
    end
  end

`ifdef TL45_FETCH_BUSERR_EN
  // Error flag travels with the buffer contents.
  always_ff @(posedge i_clk) begin
    if (i_reset || redirect)
      o_buserr <= 1'b0;
    else if (!i_pipe_stall)
      o_buserr <= load_err;
  end
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// tb/tb_tl45_fetch.sv - directed testbench for tl45_fetch
`timescale 1ns/1ps
module tb_tl45_fetch;

  logic        i_clk;
  logic        i_reset;
  logic        i_pipe_stall;
  logic        i_pipe_flush;
  logic        i_ld_newpc;
  logic [31:0] i_new_pc;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [29:0] o_wb_addr;
  logic        i_wb_stall;
  logic        i_wb_ack;
  logic [31:0] i_wb_data;
`ifdef TL45_FETCH_BUSERR_EN
  logic        i_wb_err;
  logic        o_buserr;
`endif
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;

  int          n_checks;
  int          n_errors;
  logic        auto_ack;

  tl45_fetch u_dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pipe_stall (i_pipe_stall),
    .i_pipe_flush (i_pipe_flush),
    .i_ld_newpc   (i_ld_newpc),
    .i_new_pc     (i_new_pc),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_addr    (o_wb_addr),
    .i_wb_stall   (i_wb_stall),
    .i_wb_ack     (i_wb_ack),
    .i_wb_data    (i_wb_data),
`ifdef TL45_FETCH_BUSERR_EN
    .i_wb_err     (i_wb_err),
    .o_buserr     (o_buserr),
`endif
    .o_buf_pc     (o_buf_pc),
    .o_buf_inst   (o_buf_inst)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One clock; a zero-wait slave acks the cycle after it accepts a strobe.
  task automatic step();
    logic        acc;
    logic [29:0] a;
    acc = o_wb_stb && !i_wb_stall;
    a   = o_wb_addr;
    @(posedge i_clk);
    #1;
    i_wb_ack  = auto_ack && acc;
    i_wb_data = acc ? ({a, 2'b00} ^ 32'hA5A5_A5A5) : 32'h0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    auto_ack     = 1'b1;
    i_reset      = 1'b1;
    i_pipe_stall = 1'b0;
    i_pipe_flush = 1'b0;
    i_ld_newpc   = 1'b0;
    i_new_pc     = 32'h0;
    i_wb_stall   = 1'b0;
    i_wb_ack     = 1'b0;
    i_wb_data    = 32'h0;
`ifdef TL45_FETCH_BUSERR_EN
    i_wb_err     = 1'b0;
`endif
    step();
    step();
    i_reset = 1'b0;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_bpc", o_buf_pc, 0);
    check("rst_binst", o_buf_inst, 0);

    // Zero-wait fetch of pc 0, 4.
    step();
    check("first_stb", o_wb_stb, 1);
    check("first_addr", o_wb_addr, 0);
    step();
    check("wait_cyc", o_wb_cyc, 1);
    check("wait_stb", o_wb_stb, 0);
    step();
    check("b0_pc", o_buf_pc, 32'h0);
    check("b0_inst", o_buf_inst, 32'hA5A5_A5A5);
    check("addr1", o_wb_addr, 1);
    step();
    check("bubble0", o_buf_inst, 0);
    step();
    check("b4_pc", o_buf_pc, 32'h4);
    check("b4_inst", o_buf_inst, 32'hA5A5_A5A1);

    // Downstream stall across the ack for pc 8.
    i_pipe_stall = 1'b1;
    step();
    check("stall_hold_pc_a", o_buf_pc, 32'h4);
    step();
    check("hold_cyc", o_wb_cyc, 0);
    check("stall_hold_pc_b", o_buf_pc, 32'h4);
    step();
    check("stall_hold_pc_c", o_buf_pc, 32'h4);
    check("stall_hold_inst", o_buf_inst, 32'hA5A5_A5A1);
    i_pipe_stall = 1'b0;
    step();
    check("b8_pc", o_buf_pc, 32'h8);
    check("b8_inst", o_buf_inst, 32'hA5A5_A5AD);
    check("after_hold_addr", o_wb_addr, 3);
    step();
    step();
    check("bc_pc", o_buf_pc, 32'hC);
    check("bc_inst", o_buf_inst, 32'hA5A5_A5A9);

    // Branch while waiting on pc 0x10; stale ack two cycles later.
    auto_ack = 1'b0;
    step();
    check("w10_addr", o_wb_addr, 30'h4);
    i_ld_newpc = 1'b1;
    i_new_pc   = 32'h100;
    step();
    i_ld_newpc = 1'b0;
    check("drain_cyc", o_wb_cyc, 1);
    check("drain_stb", o_wb_stb, 0);
    check("redir_bubble", o_buf_inst, 0);
    step();
    i_wb_ack  = 1'b1;
    i_wb_data = 32'hDEAD_BEEF;
    step();
    auto_ack = 1'b1;
    check("stale_dropped", o_buf_inst, 0);
    check("newpc_stb", o_wb_stb, 1);
    check("newpc_addr", o_wb_addr, 30'h40);
    step();
    step();
    check("b100_pc", o_buf_pc, 32'h100);
    check("b100_inst", o_buf_inst, 32'hA5A5_A4A5);

    // Misaligned target is word aligned.
    i_ld_newpc = 1'b1;
    i_new_pc   = 32'h203;
    step();
    i_ld_newpc = 1'b0;
    step();
    check("mis_addr", o_wb_addr, 30'h80);
    step();
    step();
    check("b200_pc", o_buf_pc, 32'h200);
    check("b200_inst", o_buf_inst, 32'hA5A5_A7A5);

    // pc wraps past the top of memory.
    i_ld_newpc = 1'b1;
    i_new_pc   = 32'hFFFF_FFFC;
    step();
    i_ld_newpc = 1'b0;
    step();
    check("top_addr", o_wb_addr, 30'h3FFF_FFFF);
    step();
    step();
    check("btop_pc", o_buf_pc, 32'hFFFF_FFFC);
    check("btop_inst", o_buf_inst, 32'h5A5A_5A59);
    check("wrap_addr", o_wb_addr, 0);
    step();
    step();
    check("bwrap_pc", o_buf_pc, 32'h0);
    check("bwrap_inst", o_buf_inst, 32'hA5A5_A5A5);

    // Flush beats stall and refetches the same pc.
    i_pipe_flush = 1'b1;
    i_pipe_stall = 1'b1;
    step();
    i_pipe_flush = 1'b0;
    i_pipe_stall = 1'b0;
    check("flush_inst", o_buf_inst, 0);
    step();
    check("refetch_addr", o_wb_addr, 1);

    // Slave stall keeps the strobe up.
    i_wb_stall = 1'b1;
    step();
    i_wb_stall = 1'b0;
    check("wbstall_stb", o_wb_stb, 1);
    check("wbstall_addr", o_wb_addr, 1);
    step();
    step();
    check("b4b_pc", o_buf_pc, 32'h4);
    check("b4b_inst", o_buf_inst, 32'hA5A5_A5A1);

    // Reset in S_WAIT; late ack ignored.
    step();
    i_reset = 1'b1;
    step();
    i_reset  = 1'b0;
    auto_ack = 1'b0;
    check("rst2_cyc", o_wb_cyc, 0);
    check("rst2_binst", o_buf_inst, 0);
    i_wb_ack  = 1'b1;
    i_wb_data = 32'h1234_5678;
    step();
    auto_ack = 1'b1;
    check("late_ack_inst", o_buf_inst, 0);
    check("rst2_stb", o_wb_stb, 1);
    check("rst2_addr", o_wb_addr, 0);
    step();
    step();
    check("rst2_b0", o_buf_inst, 32'hA5A5_A5A5);

`ifdef TL45_FETCH_BUSERR_EN
    // Bus error on pc 0x20 parks fetch until a redirect.
    i_ld_newpc = 1'b1;
    i_new_pc   = 32'h20;
    step();
    i_ld_newpc = 1'b0;
    step();
    auto_ack = 1'b0;
    check("err_addr", o_wb_addr, 30'h8);
    step();
    i_wb_err = 1'b1;
    step();
    i_wb_err = 1'b0;
    check("err_flag", o_buserr, 1);
    check("err_inst", o_buf_inst, 0);
    check("err_pc", o_buf_pc, 32'h20);
    check("err_cyc", o_wb_cyc, 0);
    step();
    check("park_stb_a", o_wb_stb, 0);
    check("err_clear", o_buserr, 0);
    step();
    step();
    check("park_stb_b", o_wb_stb, 0);
    auto_ack   = 1'b1;
    i_ld_newpc = 1'b1;
    i_new_pc   = 32'h40;
    step();
    i_ld_newpc = 1'b0;
    step();
    check("resume_stb", o_wb_stb, 1);
    check("resume_addr", o_wb_addr, 30'h10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
